inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Instruction fetch and sequencing unit that produces the instruction stream consumed by the HV encoder instruction decoder.
- Holds a small program in a flop-based instruction memory, loaded through a config write port.
- Steps a program counter and repeats the program a configured number of times.
- Drives instruction code plus enable toward the decoder and honours a downstream stall.

Parameters:
- InstWidth, 32, instruction word width; must match the decoder.
- NumInsts, 64, instruction memory depth.
- LoopCountWidth, 16, width of the program-repeat counter.
- InstAddrWidth, $clog2(NumInsts), derived; do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_wr_en_i  in  1  instruction memory write strobe.
- cfg_wr_addr_i  in  InstAddrWidth  write address.
- cfg_wr_data_i  in  InstWidth  write data.
- cfg_last_addr_i  in  InstAddrWidth  address of the last program instruction.
- cfg_loop_count_i  in  LoopCountWidth  number of program passes; 0 = run until stopped.
- start_i  in  1  start request.
- stop_i  in  1  abort request.
- stall_i  in  1  downstream not ready, e.g. IM empty or AM busy.
- inst_code_o  out  InstWidth  instruction to the decoder.
- inst_valid_o  out  1  instruction issued this cycle; connects to the decoder enable.
- pc_o  out  InstAddrWidth  current program counter.
- loop_iter_o  out  LoopCountWidth  completed passes in the current run.
- busy_o  out  1  high while in RUN.
- done_o  out  1  single-cycle pulse on normal completion.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async, rst_ni=0):
  - state=IDLE; pc=0; iter=0; captured config registers=0; all memory words=0.
  - inst_code_o=0, inst_valid_o=0, pc_o=0, loop_iter_o=0, busy_o=0, done_o=0.
  - Reset asserted mid-run aborts immediately. No done_o pulse is produced.
- IDLE:
  - cfg_wr_en_i writes mem[cfg_wr_addr_i] at the clock edge.
  - start_i=1 moves to RUN and sets pc=0, iter=0.
  - On start, cfg_last_addr_i and cfg_loop_count_i are captured into internal registers. Changes to these inputs during RUN are ignored.
  - If a write and start_i occur in the same cycle, both take effect. The first fetch in RUN sees the new data.
  - stop_i is ignored.
- RUN:
  - cfg_wr_en_i is ignored; memory is unchanged.
  - start_i is ignored.
- Fetch (RUN):
  - inst_code_o = mem[pc] via asynchronous read.
  - inst_valid_o = (state==RUN) && !stall_i && !stop_i.
  - In every non-RUN state, inst_code_o=0 and inst_valid_o=0, so the decoder sees zero.
- Issue rule, per cycle in RUN:
  - stop_i=1 (highest priority): no issue; next state IDLE; pc and iter are held, no done_o.
  - else if stall_i=1: pc and iter are held; nothing is issued.
  - else the instruction issues and advances as follows:
    - If pc != last: pc=pc+1.
    - If pc == last: iter=iter+1 (saturating at all-ones). Then:
      - if loop_count!=0 and iter+1==loop_count: next state DONE, pc held;
      - otherwise pc=0 (wrap).
- Latency: exactly one instruction per non-stalled RUN cycle; no bubble at wrap-around.
- DONE: lasts one cycle with done_o=1, busy_o=0, inst_valid_o=0; then always goes to IDLE.
- busy_o = (state==RUN).
- pc_o and loop_iter_o are the registered values and stay visible in IDLE until the next start.
- Boundary conditions:
  - last=0 is a one-instruction program that repeats at address 0.
  - last=NumInsts-1 wraps to 0 correctly.
  - loop_count=1 gives exactly last+1 issues.
  - With loop_count=0 the run never reaches DONE; iter saturates.

Test Plan:
- Reset mid-RUN at pc=5 -> all outputs 0 asynchronously; after release state=IDLE; memory reads 0.
- Load mem[0..3]=0xA0..0xA3; last=3, loop_count=2; start with no stall -> inst_valid_o high for 8 consecutive cycles. Codes are A0,A1,A2,A3,A0,A1,A2,A3. Then done_o pulses once, busy_o drops, loop_iter_o=2.
- Same program with stall_i=1 on cycles 2-4 of RUN -> no issue while stalled; the stalled instruction (A1) issues when the stall releases; total issues still 8.
- loop_count=0, last=0, mem[0]=0x55; run 20 cycles then stop_i -> 20 issues of 0x55; no issue on the stop cycle; IDLE next cycle; done_o never asserted.
- cfg write to address 1 during RUN -> mem[1] unchanged after returning to IDLE.
- Write mem[0]=0x77 and start_i in the same IDLE cycle, last=0, loop_count=1 -> a single issue of 0x77, then done_o.

Source files
------------

// File: rtl/inst_sequencer.sv
// Instruction fetch/sequencing unit: flop-based program memory, PC stepping with
// program repeat, and a stall-aware issue stream toward the HV encoder decoder.
module inst_sequencer #(
   parameter int InstWidth      = 32,
   parameter int NumInsts       = 64,
   parameter int LoopCountWidth = 16,
   parameter int InstAddrWidth  = $clog2(NumInsts)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cfg_wr_en_i,
   input  logic [InstAddrWidth-1:0]  cfg_wr_addr_i,
   input  logic [InstWidth-1:0]      cfg_wr_data_i,
   input  logic [InstAddrWidth-1:0]  cfg_last_addr_i,
   input  logic [LoopCountWidth-1:0] cfg_loop_count_i,
   input  logic                      start_i,
   input  logic                      stop_i,
   input  logic                      stall_i,
   output logic [InstWidth-1:0]      inst_code_o,
   output logic                      inst_valid_o,
   output logic [InstAddrWidth-1:0]  pc_o,
   output logic [LoopCountWidth-1:0] loop_iter_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [1:0]                dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [InstAddrWidth-1:0]  PcOne   = 1;
   localparam logic [LoopCountWidth-1:0] IterOne = 1;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [InstWidth-1:0]      r_mem [NumInsts];
   logic [InstAddrWidth-1:0]  r_pc;
   logic [InstAddrWidth-1:0]  w_pc_nxt;
   logic [LoopCountWidth-1:0] r_iter;
   logic [LoopCountWidth-1:0] w_iter_nxt;
   logic [LoopCountWidth-1:0] w_iter_inc;
   logic [InstAddrWidth-1:0]  r_last;
   logic [LoopCountWidth-1:0] r_loop_cnt;
   logic                      w_capture;
   logic                      w_issue;
   logic                      w_mem_we;

   assign w_iter_inc = r_iter + IterOne;
   assign w_mem_we   = (r_state == ST_IDLE) && cfg_wr_en_i;

   // Issue handshake: inst_valid_o is high only in RUN when the downstream is
   // ready (!stall_i) and no abort is pending; an issued word is consumed that
   // same cycle and the PC advances at the following edge.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_iter_nxt  = r_iter;
      w_capture   = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_nxt = ST_RUN;
               w_pc_nxt    = '0;
               w_iter_nxt  = '0;
               w_capture   = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop_i) begin
               w_state_nxt = ST_IDLE;
            end else if (!stall_i) begin
               w_issue = 1'b1;
               if (r_pc != r_last) begin
                  w_pc_nxt = r_pc + PcOne;
               end else begin
                  w_iter_nxt = (&r_iter) ? r_iter : w_iter_inc;
                  // An all-ones iter wraps w_iter_inc to 0, which never matches a nonzero count.
                  if ((r_loop_cnt != '0) && (w_iter_inc == r_loop_cnt)) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_pc_nxt = '0;
                  end
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_iter     <= '0;
         r_last     <= '0;
         r_loop_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_iter  <= w_iter_nxt;
         if (w_capture) begin
            r_last     <= cfg_last_addr_i;
            r_loop_cnt <= cfg_loop_count_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumInsts; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_mem_we) begin
         r_mem[cfg_wr_addr_i] <= cfg_wr_data_i;
      end
   end

   // Outside RUN the decoder must see an all-zero instruction.
   assign inst_code_o  = (r_state == ST_RUN) ? r_mem[r_pc] : '0;
   assign inst_valid_o = w_issue;
   assign pc_o         = r_pc;
   assign loop_iter_o  = r_iter;
   assign busy_o       = (r_state == ST_RUN);
   assign done_o       = (r_state == ST_DONE);
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: expected instruction stream is queued at
// start and popped whenever the sequencer issues.
module tb_inst_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cfg_wr_en;
   logic [5:0]  cfg_wr_addr;
   logic [31:0] cfg_wr_data;
   logic [5:0]  cfg_last_addr;
   logic [15:0] cfg_loop_count;
   logic        start;
   logic        stop;
   logic        stall;
   logic [31:0] inst_code;
   logic        inst_valid;
   logic [5:0]  pc;
   logic [15:0] loop_iter;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;

   logic [31:0] exp_q[$];
   logic [31:0] mem_model [64];
   int          check_cnt = 0;
   int          pass_cnt  = 0;
   int          fail_cnt  = 0;
   int          issue_cnt = 0;
   int          done_cnt  = 0;
   int          rc        = 0;
   bit          saw_done  = 0;

   inst_sequencer dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .cfg_wr_en_i      (cfg_wr_en),
      .cfg_wr_addr_i    (cfg_wr_addr),
      .cfg_wr_data_i    (cfg_wr_data),
      .cfg_last_addr_i  (cfg_last_addr),
      .cfg_loop_count_i (cfg_loop_count),
      .start_i          (start),
      .stop_i           (stop),
      .stall_i          (stall),
      .inst_code_o      (inst_code),
      .inst_valid_o     (inst_valid),
      .pc_o             (pc),
      .loop_iter_o      (loop_iter),
      .busy_o           (busy),
      .done_o           (done),
      .dbg_state_o      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs already set after a falling edge, sample at +1.
   task automatic cycle();
      #1;
      if (inst_valid) begin
         issue_cnt++;
         chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("inst_code", 64'(inst_code), 64'(exp_q.pop_front()));
      end
      if (done) begin
         done_cnt++;
         saw_done = 1'b1;
         chk("done_busy", 64'(busy), 64'd0);
         chk("done_valid", 64'(inst_valid), 64'd0);
      end
      @(negedge clk);
   endtask

   task automatic wr(input logic [5:0] addr, input logic [31:0] data);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = addr;
      cfg_wr_data = data;
      mem_model[addr] = data;
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   task automatic push_prog(input int last, input int passes);
      for (int p = 0; p < passes; p++)
         for (int a = 0; a <= last; a++) exp_q.push_back(mem_model[a]);
   endtask

   // Start pulse, then scramble config inputs: the run must use captured values.
   task automatic start_run(input logic [5:0] last, input logic [15:0] loops);
      issue_cnt      = 0;
      done_cnt       = 0;
      saw_done       = 1'b0;
      cfg_last_addr  = last;
      cfg_loop_count = loops;
      start          = 1'b1;
      cycle();
      start          = 1'b0;
      cfg_wr_en      = 1'b0;
      cfg_last_addr  = ~last;
      cfg_loop_count = loops + 16'd5;
   endtask

   task automatic run_to_done(input int max_cyc, input logic [31:0] stall_mask, output int n);
      n = 0;
      while (!saw_done && n < max_cyc) begin
         n++;
         stall = (n < 32) ? stall_mask[n] : 1'b0;
         cycle();
      end
      stall = 1'b0;
      chk("done_seen", 64'(saw_done), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic post_run(input string tag, input logic [15:0] exp_iter, input logic [5:0] exp_pc);
      #1;
      chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done_once"}, 64'(done), 64'd0);
      chk({tag, "_code_zero"}, 64'(inst_code), 64'd0);
      chk({tag, "_iter"}, 64'(loop_iter), 64'(exp_iter));
      chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      cfg_last_addr = '0; cfg_loop_count = '0; start = 1'b0; stop = 1'b0; stall = 1'b0;
      for (int i = 0; i < 64; i++) mem_model[i] = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
      chk("rst_valid", 64'(inst_valid), 64'd0);
      chk("rst_code", 64'(inst_code), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Two passes of a four-word program, no stall.
      for (int a = 0; a < 4; a++) wr(6'(a), 32'hA0 + 32'(a));
      push_prog(3, 2);
      start_run(6'd3, 16'd2);
      run_to_done(40, 32'h0, rc);
      chk("t1_cycles", 64'(rc), 64'd9);
      chk("t1_issues", 64'(issue_cnt), 64'd8);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);
      post_run("t1", 16'd2, 6'd3);

      // Same program, stalled on RUN cycles 2..4.
      push_prog(3, 2);
      start_run(6'd3, 16'd2);
      run_to_done(40, 32'h0000_001C, rc);
      chk("t2_cycles", 64'(rc), 64'd12);
      chk("t2_issues", 64'(issue_cnt), 64'd8);
      post_run("t2", 16'd2, 6'd3);

      // Endless one-word program, stopped after 20 issues; write and start during RUN ignored.
      wr(6'd0, 32'h55);
      for (int i = 0; i < 20; i++) exp_q.push_back(32'h55);
      start_run(6'd0, 16'd0);
      for (int i = 0; i < 20; i++) begin
         cfg_wr_en   = (i == 5);
         start       = (i == 5);
         cfg_wr_addr = 6'd1;
         cfg_wr_data = 32'hDEAD_BEEF;
         cycle();
      end
      cfg_wr_en = 1'b0; start = 1'b0;
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      chk("t3_issues", 64'(issue_cnt), 64'd20);
      chk("t3_no_done", 64'(done_cnt), 64'd0);
      chk("t3_queue", 64'(exp_q.size()), 64'd0);
      post_run("t3", 16'd20, 6'd0);

      // mem[1] must still hold the pre-run value.
      push_prog(1, 1);
      start_run(6'd1, 16'd1);
      run_to_done(20, 32'h0, rc);
      chk("t3b_cycles", 64'(rc), 64'd3);
      post_run("t3b", 16'd1, 6'd1);

      // Write and start in the same cycle: the first fetch sees the new word.
      mem_model[0] = 32'h77;
      exp_q.push_back(32'h77);
      cfg_wr_en = 1'b1; cfg_wr_addr = 6'd0; cfg_wr_data = 32'h77;
      start_run(6'd0, 16'd1);
      run_to_done(20, 32'h0, rc);
      chk("t4_cycles", 64'(rc), 64'd2);
      chk("t4_issues", 64'(issue_cnt), 64'd1);
      post_run("t4", 16'd1, 6'd0);

      // Full-depth program wraps from 63 back to 0.
      for (int a = 0; a < 64; a++) wr(6'(a), $urandom);
      push_prog(63, 2);
      start_run(6'd63, 16'd2);
      run_to_done(300, 32'h0, rc);
      chk("t5_cycles", 64'(rc), 64'd129);
      chk("t5_issues", 64'(issue_cnt), 64'd128);
      post_run("t5", 16'd2, 6'd63);

      // Asynchronous reset in the middle of a run at pc=5.
      push_prog(4, 1);
      start_run(6'd63, 16'd0);
      repeat (5) cycle();
      #1;
      chk("t6_pc_before", 64'(pc), 64'd5);
      chk("t6_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_code", 64'(inst_code), 64'd0);
      chk("t6_rst_valid", 64'(inst_valid), 64'd0);
      chk("t6_rst_pc", 64'(pc), 64'd0);
      chk("t6_rst_iter", 64'(loop_iter), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_done", 64'(done), 64'd0);
      chk("t6_rst_state", 64'(dbg_state), 64'(S_IDLE));
      chk("t6_queue", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) mem_model[i] = '0;
      @(negedge clk);
      chk("t6_no_done", 64'(done_cnt), 64'd0);
      push_prog(3, 1);
      start_run(6'd3, 16'd1);
      run_to_done(20, 32'h0, rc);
      chk("t6_cycles", 64'(rc), 64'd5);
      post_run("t6", 16'd1, 6'd3);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
